// File: rtl/note_recorder_poly_pkg.sv
// note_recorder_poly_pkg
//   Shared definitions for the polyphonic note recorder: FSM state
//   encoding, default entry field widths and the key-index width helper.
package note_recorder_poly_pkg;

    // FSM state encoding (kept as plain constants for legacy tools)
    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_RECORD     = 3'd1;
    localparam logic [2:0] ST_PLAY_FETCH = 3'd2;
    localparam logic [2:0] ST_PLAY_WAIT  = 3'd3;
    localparam logic [2:0] ST_PLAY_RUN   = 3'd4;

    // Default widths of the start_time and duration fields of an entry
    localparam int DEF_TIME_W = 13;
    localparam int DEF_DUR_W  = 13;

    // Bits needed to hold a key index; never less than one bit
    function automatic int key_idx_w(input int num_keys);
        return (num_keys > 1) ? $clog2(num_keys) : 1;
    endfunction

endpackage

// File: rtl/note_recorder_poly_if.sv
// note_recorder_poly_if
//   Control/status bundle of the note recorder.
//   master: drives mode/start/stop/key_down, observes status and play_keys.
//   slave : the recorder itself.
interface note_recorder_poly_if #(
    parameter int NUM_KEYS = 3,
    parameter int DEPTH    = 128,
    parameter int TIME_W   = 13
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                mode;
    logic                start;
    logic                stop;
    logic [NUM_KEYS-1:0] key_down;
    logic [NUM_KEYS-1:0] play_keys;
    logic                busy;
    logic                full;
    logic                done;
    logic [CNT_W-1:0]    event_count;
    logic [TIME_W-1:0]   system_time;

    modport master (
        output mode, start, stop, key_down,
        input  play_keys, busy, full, done, event_count, system_time
    );

    modport slave (
        input  mode, start, stop, key_down,
        output play_keys, busy, full, done, event_count, system_time
    );

endinterface

// File: rtl/note_tick_gen.sv
// note_tick_gen
//   Prescaler plus saturating tick counter.
//   clock/reset : system clock, async active-high reset
//   en          : count while high
//   clear       : reload prescaler and zero system_time
//   tick        : one-cycle strobe on the cycle system_time advances
//   system_time : ticks since the last clear, sticks at all-ones
//   sat         : system_time has reached all-ones
module note_tick_gen #(
    parameter int TICK_DIV = 500000,
    parameter int TIME_W   = 13
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              en,
    input  logic              clear,
    output logic              tick,
    output logic [TIME_W-1:0] system_time,
    output logic              sat
);
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] presc;

    assign sat  = &system_time;
    assign tick = en && (presc == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc       <= PRE_MAX;
            system_time <= '0;
        end else if (clear) begin
            presc       <= PRE_MAX;
            system_time <= '0;
        end else if (en) begin
            if (presc == '0) begin
                presc <= PRE_MAX;
                if (!sat)
                    system_time <= system_time + TIME_W'(1);
            end else begin
                presc <= presc - PRE_W'(1);
            end
        end
    end

endmodule

// File: rtl/note_recorder_poly.sv
// note_recorder_poly
//   Records key press/release events into an event buffer
//   {key, start_time, duration} and plays them back polyphonically.
//   clock : system clock
//   reset : asynchronous active-high reset
//   bus   : note_recorder_poly_if.slave (mode/start/stop/key_down in,
//           play_keys/busy/full/done/event_count/system_time out)
module note_recorder_poly
    import note_recorder_poly_pkg::*;
#(
    parameter int NUM_KEYS = 3,
    parameter int DEPTH    = 128,
    parameter int TIME_W   = DEF_TIME_W,
    parameter int DUR_W    = DEF_DUR_W,
    parameter int TICK_DIV = 500000
) (
    input  logic                  clock,
    input  logic                  reset,
    note_recorder_poly_if.slave   bus
);
    localparam int KEY_W  = key_idx_w(NUM_KEYS);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int CNT_W  = IDX_W + 1;
    localparam int DIFF_W = (TIME_W > DUR_W) ? TIME_W : DUR_W;

    // Elapsed ticks, clamped to the duration field
    function automatic logic [DUR_W-1:0] sat_dur(input logic [TIME_W-1:0] now,
                                                 input logic [TIME_W-1:0] t0);
        logic [DIFF_W-1:0] diff;
        diff = DIFF_W'(now - t0);
        if (diff > DIFF_W'({DUR_W{1'b1}}))
            return '1;
        return DUR_W'(diff);
    endfunction

    logic [2:0]          state;
    logic [CNT_W-1:0]    event_count;
    logic [CNT_W-1:0]    idx;
    logic                done;
    logic [NUM_KEYS-1:0] key_prev, pending, open_k, play_keys;
    logic [IDX_W-1:0]    slot  [NUM_KEYS];
    logic [DUR_W-1:0]    timer [NUM_KEYS];
    logic [TIME_W-1:0]   ptime [NUM_KEYS];

    logic [KEY_W-1:0]    key_mem   [DEPTH];
    logic [TIME_W-1:0]   start_mem [DEPTH];
    logic [DUR_W-1:0]    dur_mem   [DEPTH];
    logic [KEY_W-1:0]    f_key;
    logic [TIME_W-1:0]   f_start;
    logic [DUR_W-1:0]    f_dur;

    logic                tick, time_sat, busy, full, in_rec, in_play, halt;
    logic                alloc_ok, load;
    logic [TIME_W-1:0]   sys_time;
    logic [NUM_KEYS-1:0] rise, fall, alloc_mask, close;
    logic [IDX_W-1:0]    wr_ptr;

    note_tick_gen #(.TICK_DIV(TICK_DIV), .TIME_W(TIME_W)) u_tick (
        .clock      (clock),
        .reset      (reset),
        .en         (busy),
        .clear      (bus.start && state == ST_IDLE),
        .tick       (tick),
        .system_time(sys_time),
        .sat        (time_sat)
    );

    assign busy     = (state != ST_IDLE);
    assign full     = (event_count == CNT_W'(DEPTH));
    assign in_rec   = (state == ST_RECORD);
    assign in_play  = (state == ST_PLAY_FETCH) || (state == ST_PLAY_WAIT) || (state == ST_PLAY_RUN);
    assign halt     = bus.stop || time_sat;
    assign rise     = bus.key_down & ~key_prev;
    assign fall     = ~bus.key_down & key_prev;
    assign alloc_ok = in_rec && !halt && !full;
    assign load     = (state == ST_PLAY_WAIT) && !halt && (sys_time >= f_start);
    assign wr_ptr   = event_count[IDX_W-1:0];
    // On exit every open key is closed at the current time
    assign close    = in_rec ? (open_k & (fall | {NUM_KEYS{halt}})) : '0;

    // Lowest pending key wins; a key released before allocation is dropped
    always_comb begin
        alloc_mask = '0;
        if (alloc_ok)
            for (int k = NUM_KEYS - 1; k >= 0; k--)
                if (pending[k] && !fall[k])
                    alloc_mask = NUM_KEYS'(1) << k;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            event_count <= '0;
            idx         <= '0;
            done        <= 1'b0;
            key_prev    <= '0;
            pending     <= '0;
            open_k      <= '0;
            play_keys   <= '0;
            for (int k = 0; k < NUM_KEYS; k++) begin
                slot[k]  <= '0;
                timer[k] <= '0;
            end
        end else begin
            done     <= 1'b0;
            key_prev <= bus.key_down;

            // Per-key playback timers run in every playback state
            if (in_play)
                for (int k = 0; k < NUM_KEYS; k++) begin
                    if (load && f_key == KEY_W'(k)) begin
                        timer[k]     <= f_dur;
                        play_keys[k] <= 1'b1;
                    end else if (timer[k] != '0) begin
                        if (tick)
                            timer[k] <= timer[k] - DUR_W'(1);
                    end else begin
                        play_keys[k] <= 1'b0;
                    end
                end

            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (!bus.mode) begin
                            state       <= ST_RECORD;
                            event_count <= '0;
                            pending     <= '0;
                            open_k      <= '0;
                        end else if (event_count == '0) begin
                            done <= 1'b1;
                        end else begin
                            state <= ST_PLAY_FETCH;
                            idx   <= '0;
                        end
                    end
                end
                ST_RECORD: begin
                    if (halt) begin
                        state   <= ST_IDLE;
                        done    <= 1'b1;
                        pending <= '0;
                        open_k  <= '0;
                    end else begin
                        open_k  <= (open_k & ~fall) | alloc_mask;
                        pending <= full ? '0 : ((pending & ~fall & ~alloc_mask) | rise);
                        if (alloc_mask != '0)
                            event_count <= event_count + CNT_W'(1);
                        for (int k = 0; k < NUM_KEYS; k++)
                            if (alloc_mask[k])
                                slot[k] <= wr_ptr;
                    end
                end
                ST_PLAY_FETCH: state <= ST_PLAY_WAIT;
                ST_PLAY_WAIT: begin
                    if (load) begin
                        idx   <= idx + CNT_W'(1);
                        state <= ((idx + CNT_W'(1)) < event_count) ? ST_PLAY_FETCH : ST_PLAY_RUN;
                    end
                end
                ST_PLAY_RUN: begin
                    if (play_keys == '0) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (in_play && halt) begin
                state     <= ST_IDLE;
                done      <= 1'b1;
                play_keys <= '0;
                for (int k = 0; k < NUM_KEYS; k++)
                    timer[k] <= '0;
            end
        end
    end

    // Event buffer and per-key data; contents survive reset
    always_ff @(posedge clock) begin
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (alloc_mask[k]) begin
                key_mem[wr_ptr]   <= KEY_W'(k);
                start_mem[wr_ptr] <= ptime[k];
                dur_mem[wr_ptr]   <= '0;
            end
        end
        for (int k = 0; k < NUM_KEYS; k++)
            if (close[k])
                dur_mem[slot[k]] <= sat_dur(sys_time, ptime[k]);
        for (int k = 0; k < NUM_KEYS; k++)
            if (rise[k])
                ptime[k] <= sys_time;
        if (state == ST_PLAY_FETCH) begin
            f_key   <= key_mem[idx[IDX_W-1:0]];
            f_start <= start_mem[idx[IDX_W-1:0]];
            f_dur   <= dur_mem[idx[IDX_W-1:0]];
        end
    end

    assign bus.play_keys   = play_keys;
    assign bus.busy        = busy;
    assign bus.full        = full;
    assign bus.done        = done;
    assign bus.event_count = event_count;
    assign bus.system_time = sys_time;

endmodule

// File: tb/tb_note_recorder_poly.sv
// tb_note_recorder_poly
//   Directed bench for note_recorder_poly with TICK_DIV=4, DEPTH=4, 3 keys.
module tb_note_recorder_poly;
    localparam int NUM_KEYS = 3;
    localparam int DEPTH    = 4;
    localparam int TIME_W   = 13;
    localparam int DUR_W    = 13;
    localparam int TICK_DIV = 4;

    logic clock;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    note_recorder_poly_if #(.NUM_KEYS(NUM_KEYS), .DEPTH(DEPTH), .TIME_W(TIME_W)) bus ();

    note_recorder_poly #(
        .NUM_KEYS(NUM_KEYS), .DEPTH(DEPTH), .TIME_W(TIME_W),
        .DUR_W(DUR_W), .TICK_DIV(TICK_DIV)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Advance to the first negedge at which system_time equals t
    task automatic wait_time(input int t);
        int n;
        n = 0;
        while (int'(bus.system_time) != t && n < 2000) begin
            @(negedge clock);
            n++;
        end
        if (int'(bus.system_time) != t)
            check("wait_time", 32'(bus.system_time), 32'(t));
    endtask

    task automatic pulse_start(input logic m);
        bus.mode  = m;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1;
        @(negedge clock);
        bus.stop = 1'b0;
    endtask

    task automatic check_entry(input string tag, input int i,
                               input int k, input int st, input int du);
        check({tag, ".key"},   32'(dut.key_mem[i]),   32'(k));
        check({tag, ".start"}, 32'(dut.start_mem[i]), 32'(st));
        check({tag, ".dur"},   32'(dut.dur_mem[i]),   32'(du));
    endtask

    task automatic sample_keys(input string tag, input int t, input int exp);
        wait_time(t);
        step(2);
        check(tag, 32'(bus.play_keys), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        reset        = 1'b1;
        bus.mode     = 1'b0;
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.key_down = '0;
        step(2);
        check("rst.play_keys",   32'(bus.play_keys),   0);
        check("rst.busy",        32'(bus.busy),        0);
        check("rst.full",        32'(bus.full),        0);
        check("rst.done",        32'(bus.done),        0);
        check("rst.event_count", 32'(bus.event_count), 0);
        check("rst.system_time", 32'(bus.system_time), 0);
        reset = 1'b0;
        step(1);

        // Single note: press at 5, release at 25
        pulse_start(1'b0);
        check("t1.busy", 32'(bus.busy), 1);
        wait_time(5);  bus.key_down = 3'b001;
        wait_time(25); bus.key_down = 3'b000;
        step(1);
        pulse_stop();
        check("t1.done",  32'(bus.done), 1);
        check("t1.busy0", 32'(bus.busy), 0);
        step(1);
        check("t1.done_pulse", 32'(bus.done), 0);
        check("t1.count", 32'(bus.event_count), 1);
        check_entry("t1.e0", 0, 0, 5, 20);

        // Simultaneous presses of key0 and key2
        pulse_start(1'b0);
        wait_time(3);  bus.key_down = 3'b101;
        wait_time(10); bus.key_down = 3'b100;
        wait_time(12); bus.key_down = 3'b000;
        step(1);
        pulse_stop();
        check("t2.count", 32'(bus.event_count), 2);
        check_entry("t2.e0", 0, 0, 3, 7);
        check_entry("t2.e1", 1, 2, 3, 9);

        // Buffer fills after four notes; fifth press is dropped
        pulse_start(1'b0);
        for (int i = 0; i < 4; i++) begin
            wait_time(2 + 2 * i); bus.key_down = 3'b001;
            wait_time(3 + 2 * i); bus.key_down = 3'b000;
        end
        wait_time(10);
        check("t3.full",  32'(bus.full), 1);
        check("t3.count", 32'(bus.event_count), 4);
        bus.key_down = 3'b010;
        wait_time(12); bus.key_down = 3'b000;
        step(2);
        check("t3.count_after", 32'(bus.event_count), 4);
        check_entry("t3.e0", 0, 0, 2, 1);
        check_entry("t3.e3", 3, 0, 8, 1);
        pulse_stop();
        check("t3.done", 32'(bus.done), 1);

        // Key still held when stop arrives
        pulse_start(1'b0);
        check("t4.full_clr", 32'(bus.full), 0);
        wait_time(30); bus.key_down = 3'b010;
        wait_time(40);
        pulse_stop();
        check("t4.done", 32'(bus.done), 1);
        check("t4.busy", 32'(bus.busy), 0);
        step(1);
        check("t4.done_pulse", 32'(bus.done), 0);
        check("t4.count", 32'(bus.event_count), 1);
        check_entry("t4.e0", 0, 1, 30, 10);
        bus.key_down = 3'b000;
        step(2);

        // Record {0,5,20},{2,8,4} then play it back
        pulse_start(1'b0);
        wait_time(5);  bus.key_down = 3'b001;
        wait_time(8);  bus.key_down = 3'b101;
        wait_time(12); bus.key_down = 3'b001;
        wait_time(25); bus.key_down = 3'b000;
        step(1);
        pulse_stop();
        check("t5.count", 32'(bus.event_count), 2);
        check_entry("t5.e0", 0, 0, 5, 20);
        check_entry("t5.e1", 1, 2, 8, 4);

        pulse_start(1'b1);
        check("t5.busy", 32'(bus.busy), 1);
        sample_keys("t5.pk@4",  4,  3'b000);
        sample_keys("t5.pk@5",  5,  3'b001);
        sample_keys("t5.pk@7",  7,  3'b001);
        sample_keys("t5.pk@8",  8,  3'b101);
        sample_keys("t5.pk@11", 11, 3'b101);
        sample_keys("t5.pk@12", 12, 3'b001);
        sample_keys("t5.pk@24", 24, 3'b001);
        wait_time(25);
        seen = 0;
        for (int i = 0; i < 8 && seen == 0; i++) begin
            @(negedge clock);
            if (bus.done) seen = 1;
        end
        check("t5.done_seen", 32'(seen), 1);
        check("t5.done_time", 32'(bus.system_time), 25);
        check("t5.pk_end",    32'(bus.play_keys), 0);
        check("t5.busy_end",  32'(bus.busy), 0);

        // Asynchronous reset in the middle of playback
        pulse_start(1'b1);
        wait_time(13);
        step(1);
        check("t6.pk_before", 32'(bus.play_keys), 3'b001);
        #2;
        reset = 1'b1;
        #1;
        check("t6.pk_rst",    32'(bus.play_keys),   0);
        check("t6.busy_rst",  32'(bus.busy),        0);
        check("t6.count_rst", 32'(bus.event_count), 0);
        @(negedge clock);
        reset = 1'b0;
        step(1);

        // Playback with an empty buffer finishes at once
        pulse_start(1'b1);
        check("t7.done", 32'(bus.done), 1);
        check("t7.busy", 32'(bus.busy), 0);
        step(1);
        check("t7.done_pulse", 32'(bus.done), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
